// File: rtl/branch_resolve_if.sv
// Fetch-prediction / execute-resolution bundle between the front end and branch_resolve.
// slave is the resolver side; master is the pipeline (or bench) side.
interface branch_resolve_if #(
  parameter int XLEN = 32
);
  logic            pred_valid;
  logic            pred_taken;
  logic [XLEN-1:0] pred_pc;
  logic [XLEN-1:0] pred_target;
  logic            res_valid;
  logic            res_taken;
  logic [XLEN-1:0] res_target;
  logic            full;
  logic            empty;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [15:0]     br_cnt;
  logic [15:0]     mis_cnt;
  logic            underflow;

  modport slave (
    input  pred_valid, pred_taken, pred_pc, pred_target,
    input  res_valid, res_taken, res_target,
    output full, empty, mispredict, redirect_pc,
    output upd_valid, upd_pc, upd_taken, br_cnt, mis_cnt, underflow
  );

  modport master (
    output pred_valid, pred_taken, pred_pc, pred_target,
    output res_valid, res_taken, res_target,
    input  full, empty, mispredict, redirect_pc,
    input  upd_valid, upd_pc, upd_taken, br_cnt, mis_cnt, underflow
  );
endinterface

// File: rtl/branch_resolve.sv
// In-order queue of fetch-time branch predictions, checked against execute resolution.
// Drives fetch redirect/flush, predictor training strobe and saturating statistics.
module branch_resolve #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_resolve_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            taken;
    logic [XLEN-1:0] target;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic            mispredict_q, mispredict_d;
  logic            upd_valid_q, upd_valid_d;
  logic            upd_taken_q, upd_taken_d;
  logic            underflow_q, underflow_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [XLEN-1:0] upd_pc_q, upd_pc_d;
  logic [15:0]     br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;

  logic   full, empty, push, pop, miss;
  entry_t head;

  always_comb begin
    full  = (rd_ptr_q[AW] != wr_ptr_q[AW]) && (rd_ptr_q[AW-1:0] == wr_ptr_q[AW-1:0]);
    empty = (rd_ptr_q == wr_ptr_q);
    pop   = bus.res_valid && !empty;
    push  = bus.pred_valid && (!full || bus.res_valid);
    head  = mem_q[rd_ptr_q[AW-1:0]];
    miss  = (bus.res_taken != head.taken) ||
            (bus.res_taken && head.taken && (bus.res_target != head.target));

    mem_d         = mem_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    mispredict_d  = 1'b0;
    upd_valid_d   = 1'b0;
    upd_taken_d   = upd_taken_q;
    upd_pc_d      = upd_pc_q;
    redirect_pc_d = redirect_pc_q;
    br_cnt_d      = br_cnt_q;
    mis_cnt_d     = mis_cnt_q;
    underflow_d   = underflow_q || (bus.res_valid && empty);

    // A push on the same edge as a mispredicting pop is wrong-path and is dropped.
    if (push && !(pop && miss)) begin
      mem_d[wr_ptr_q[AW-1:0]] = '{pc: bus.pred_pc, taken: bus.pred_taken,
                                  target: bus.pred_target};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d      = rd_ptr_q + 1'b1;
      upd_valid_d   = 1'b1;
      upd_pc_d      = head.pc;
      upd_taken_d   = bus.res_taken;
      mispredict_d  = miss;
      redirect_pc_d = bus.res_taken ? bus.res_target
                                    : head.pc + {{(XLEN-3){1'b0}}, 3'd4};
      if (br_cnt_q != 16'hFFFF) br_cnt_d = br_cnt_q + 16'd1;
      if (miss) begin
        wr_ptr_d = rd_ptr_q + 1'b1;
        if (mis_cnt_q != 16'hFFFF) mis_cnt_d = mis_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      mispredict_q  <= 1'b0;
      upd_valid_q   <= 1'b0;
      upd_taken_q   <= 1'b0;
      underflow_q   <= 1'b0;
      redirect_pc_q <= '0;
      upd_pc_q      <= '0;
      br_cnt_q      <= '0;
      mis_cnt_q     <= '0;
    end else begin
      mem_q         <= mem_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      mispredict_q  <= mispredict_d;
      upd_valid_q   <= upd_valid_d;
      upd_taken_q   <= upd_taken_d;
      underflow_q   <= underflow_d;
      redirect_pc_q <= redirect_pc_d;
      upd_pc_q      <= upd_pc_d;
      br_cnt_q      <= br_cnt_d;
      mis_cnt_q     <= mis_cnt_d;
    end
  end

  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.mispredict  = mispredict_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.upd_valid   = upd_valid_q;
  assign bus.upd_pc      = upd_pc_q;
  assign bus.upd_taken   = upd_taken_q;
  assign bus.br_cnt      = br_cnt_q;
  assign bus.mis_cnt     = mis_cnt_q;
  assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: vector table of single-cycle operations plus
// hand sequences for underflow, counter saturation and mid-stream reset.
module tb_branch_resolve;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  branch_resolve_if #(.XLEN(32)) bif ();

  branch_resolve #(.DEPTH(4), .XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  typedef struct {
    bit          pv, pt;
    logic [31:0] ppc, ptg;
    bit          rv, rt;
    logic [31:0] rtg;
    bit          e_full, e_empty, e_mis, e_upd;
    logic [31:0] e_redir, e_upc;
    bit          e_utk;
    logic [15:0] e_br, e_mc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit pv, bit pt, int unsigned ppc, int unsigned ptg,
                              bit rv, bit rt, int unsigned rtg,
                              bit f, bit e, bit m, bit u,
                              int unsigned rd, int unsigned up, bit ut,
                              int unsigned br, int unsigned mc);
    vec_t v;
    v.pv = pv; v.pt = pt; v.ppc = ppc; v.ptg = ptg;
    v.rv = rv; v.rt = rt; v.rtg = rtg;
    v.e_full = f; v.e_empty = e; v.e_mis = m; v.e_upd = u;
    v.e_redir = rd; v.e_upc = up; v.e_utk = ut;
    v.e_br = br[15:0]; v.e_mc = mc[15:0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit pv, input bit pt, input logic [31:0] ppc,
                       input logic [31:0] ptg, input bit rv, input bit rt,
                       input logic [31:0] rtg);
    bif.pred_valid = pv; bif.pred_taken = pt; bif.pred_pc = ppc; bif.pred_target = ptg;
    bif.res_valid  = rv; bif.res_taken  = rt; bif.res_target = rtg;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " empty"},       32'(bif.empty), 32'd1);
    chk({tag, " full"},        32'(bif.full), 32'd0);
    chk({tag, " mispredict"},  32'(bif.mispredict), 32'd0);
    chk({tag, " upd_valid"},   32'(bif.upd_valid), 32'd0);
    chk({tag, " underflow"},   32'(bif.underflow), 32'd0);
    chk({tag, " redirect_pc"}, bif.redirect_pc, 32'd0);
    chk({tag, " upd_pc"},      bif.upd_pc, 32'd0);
    chk({tag, " upd_taken"},   32'(bif.upd_taken), 32'd0);
    chk({tag, " br_cnt"},      32'(bif.br_cnt), 32'd0);
    chk({tag, " mis_cnt"},     32'(bif.mis_cnt), 32'd0);
  endtask

  initial begin
    //           pv pt ppc          ptg     rv rt rtg      f e m u redir        upc          ut br mc
    tbl.push_back(mk(1,1,'h100,'h200,        0,0,0,       0,0,0,0, 'h0,'h0,0,        0,0));
    tbl.push_back(mk(0,0,0,0,                1,1,'h200,   0,1,0,1, 'h200,'h100,1,    1,0));
    tbl.push_back(mk(0,0,0,0,                0,0,0,       0,1,0,0, 'h200,'h100,1,    1,0));
    tbl.push_back(mk(1,1,'h100,'h200,        0,0,0,       0,0,0,0, 'h200,'h100,1,    1,0));
    tbl.push_back(mk(1,0,'h104,0,            0,0,0,       0,0,0,0, 'h200,'h100,1,    1,0));
    tbl.push_back(mk(1,0,'h108,0,            0,0,0,       0,0,0,0, 'h200,'h100,1,    1,0));
    tbl.push_back(mk(0,0,0,0,                1,0,0,       0,1,1,1, 'h104,'h100,0,    2,1));
    tbl.push_back(mk(1,1,'h40,'h80,          0,0,0,       0,0,0,0, 'h104,'h100,0,    2,1));
    tbl.push_back(mk(0,0,0,0,                1,1,'h90,    0,1,1,1, 'h90,'h40,1,      3,2));
    tbl.push_back(mk(1,0,'h10,'h55,          0,0,0,       0,0,0,0, 'h90,'h40,1,      3,2));
    tbl.push_back(mk(0,0,0,0,                1,0,'h77,    0,1,0,1, 'h14,'h10,0,      4,2));
    tbl.push_back(mk(1,0,'h20,0,             0,0,0,       0,0,0,0, 'h14,'h10,0,      4,2));
    tbl.push_back(mk(0,0,0,0,                1,1,'h300,   0,1,1,1, 'h300,'h20,1,     5,3));
    tbl.push_back(mk(1,1,'hA0,'hB0,          0,0,0,       0,0,0,0, 'h300,'h20,1,     5,3));
    tbl.push_back(mk(1,1,'hA4,'hB4,          0,0,0,       0,0,0,0, 'h300,'h20,1,     5,3));
    tbl.push_back(mk(1,0,'hA8,0,             0,0,0,       0,0,0,0, 'h300,'h20,1,     5,3));
    tbl.push_back(mk(1,1,'hAC,'hBC,          0,0,0,       1,0,0,0, 'h300,'h20,1,     5,3));
    tbl.push_back(mk(1,1,'hF0,'hF8,          1,1,'hB0,    1,0,0,1, 'hB0,'hA0,1,      6,3));
    tbl.push_back(mk(0,0,0,0,                1,1,'hB4,    0,0,0,1, 'hB4,'hA4,1,      7,3));
    tbl.push_back(mk(0,0,0,0,                1,0,0,       0,0,0,1, 'hAC,'hA8,0,      8,3));
    tbl.push_back(mk(0,0,0,0,                1,1,'hBC,    0,0,0,1, 'hBC,'hAC,1,      9,3));
    tbl.push_back(mk(0,0,0,0,                1,1,'hF8,    0,1,0,1, 'hF8,'hF0,1,      10,3));
    tbl.push_back(mk(1,1,'hC0,'hD0,          0,0,0,       0,0,0,0, 'hF8,'hF0,1,      10,3));
    tbl.push_back(mk(1,0,'hC4,0,             1,0,0,       0,1,1,1, 'hC4,'hC0,0,      11,4));
    tbl.push_back(mk(0,0,0,0,                0,0,0,       0,1,0,0, 'hC4,'hC0,0,      11,4));
    tbl.push_back(mk(1,0,'hFFFF_FFFC,0,      0,0,0,       0,0,0,0, 'hC4,'hC0,0,      11,4));
    tbl.push_back(mk(0,0,0,0,                1,0,0,       0,1,0,1, 'h0,'hFFFF_FFFC,0, 12,4));

    drive(0, 0, 0, 0, 0, 0, 0);
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].pv, tbl[i].pt, tbl[i].ppc, tbl[i].ptg, tbl[i].rv, tbl[i].rt, tbl[i].rtg);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d full", i),        32'(bif.full),       32'(tbl[i].e_full));
      chk($sformatf("v%0d empty", i),       32'(bif.empty),      32'(tbl[i].e_empty));
      chk($sformatf("v%0d mispredict", i),  32'(bif.mispredict), 32'(tbl[i].e_mis));
      chk($sformatf("v%0d upd_valid", i),   32'(bif.upd_valid),  32'(tbl[i].e_upd));
      chk($sformatf("v%0d redirect_pc", i), bif.redirect_pc,     tbl[i].e_redir);
      chk($sformatf("v%0d upd_pc", i),      bif.upd_pc,          tbl[i].e_upc);
      chk($sformatf("v%0d upd_taken", i),   32'(bif.upd_taken),  32'(tbl[i].e_utk));
      chk($sformatf("v%0d br_cnt", i),      32'(bif.br_cnt),     32'(tbl[i].e_br));
      chk($sformatf("v%0d mis_cnt", i),     32'(bif.mis_cnt),    32'(tbl[i].e_mc));
    end

    // Resolve with nothing in flight: sticky underflow, no pop side effects.
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 1, 32'h500);
    @(posedge clk);
    #1;
    chk("uflow underflow",  32'(bif.underflow), 32'd1);
    chk("uflow br_cnt",     32'(bif.br_cnt), 32'd12);
    chk("uflow upd_valid",  32'(bif.upd_valid), 32'd0);
    chk("uflow mispredict", 32'(bif.mispredict), 32'd0);
    chk("uflow redirect",   bif.redirect_pc, 32'd0);
    chk("uflow empty",      32'(bif.empty), 32'd1);
    @(negedge clk);
    drive(1, 1, 32'h300, 32'h400, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("uflow sticky", 32'(bif.underflow), 32'd1);

    // Saturation: preload the branch counter at its ceiling, then resolve a hit.
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    force dut.br_cnt_q = 16'hFFFF;
    #1;
    release dut.br_cnt_q;
    drive(0, 0, 0, 0, 1, 1, 32'h400);
    @(posedge clk);
    #1;
    chk("sat br_cnt",    32'(bif.br_cnt), 32'h0000_FFFF);
    chk("sat mis_cnt",   32'(bif.mis_cnt), 32'd4);
    chk("sat upd_pc",    bif.upd_pc, 32'h300);
    chk("sat upd_valid", 32'(bif.upd_valid), 32'd1);
    chk("sat underflow", 32'(bif.underflow), 32'd1);

    // Mid-stream reset with entries in flight.
    @(negedge clk);
    drive(1, 1, 32'h600, 32'h700, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 32'h604, 32'h0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("pre-rst empty", 32'(bif.empty), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-rst empty", 32'(bif.empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
